// File: rtl/bus_arbiter_2m.sv
// ============================================================================
// bus_arbiter_2m : round-robin arbiter sharing one register-slave port
//                  between two requesters, with slave-response timeout.
// Revision 1.0
// ============================================================================
`default_nettype none

module bus_arbiter_2m #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_m0_req,
    input  logic              io_m0_wr,
    input  logic              io_m0_rd,
    input  logic [ADDR_W-1:0] io_m0_address,
    input  logic [DATA_W-1:0] io_m0_wdata,
    output logic              io_m0_done,
    output logic              io_m0_err,
    output logic [DATA_W-1:0] io_m0_rdata,
    input  logic              io_m1_req,
    input  logic              io_m1_wr,
    input  logic              io_m1_rd,
    input  logic [ADDR_W-1:0] io_m1_address,
    input  logic [DATA_W-1:0] io_m1_wdata,
    output logic              io_m1_done,
    output logic              io_m1_err,
    output logic [DATA_W-1:0] io_m1_rdata,
    output logic              io_slv_valid,
    output logic              io_slv_wr,
    output logic              io_slv_rd,
    output logic [ADDR_W-1:0] io_slv_address,
    output logic [DATA_W-1:0] io_slv_wdata,
    input  logic              io_slv_ready,
    input  logic [DATA_W-1:0] io_slv_rdata,
    output logic              io_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] C_TMO_LIM = TIMEOUT[7:0];

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                grant_q, grant_d;
    logic [7:0]          tmo_q, tmo_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;

    // m1 wins when it is the only requester, or both request and the pointer names m1.
    logic                w_pick1;
    logic                w_sel_wr;
    logic                w_sel_rd;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [7:0]          w_tmo_inc;

    assign w_pick1     = io_m1_req & (~io_m0_req | prio_q);
    assign w_sel_wr    = w_pick1 ? io_m1_wr      : io_m0_wr;
    assign w_sel_rd    = w_pick1 ? io_m1_rd      : io_m0_rd;
    assign w_sel_addr  = w_pick1 ? io_m1_address : io_m0_address;
    assign w_sel_wdata = w_pick1 ? io_m1_wdata   : io_m0_wdata;
    assign w_tmo_inc   = tmo_q + 8'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            grant_q  <= 1'b0;
            tmo_q    <= 8'd0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            grant_q  <= grant_d;
            tmo_q    <= tmo_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        grant_d  = grant_q;
        tmo_d    = tmo_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (io_m0_req | io_m1_req) begin
                    grant_d = w_pick1;
                    wr_d    = w_sel_wr;
                    rd_d    = w_sel_rd & ~w_sel_wr;
                    addr_d  = w_sel_addr;
                    wdata_d = w_sel_wdata;
                    tmo_d   = 8'd0;
                    // A command with neither wr nor rd never touches the slave.
                    err_d   = ~(w_sel_wr | w_sel_rd);
                    state_d = (w_sel_wr | w_sel_rd) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                tmo_d = w_tmo_inc;
                if (io_slv_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                    if (rd_q) begin
                        if (grant_q) rdata1_d = io_slv_rdata;
                        else         rdata0_d = io_slv_rdata;
                    end
                end else if (w_tmo_inc == C_TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    if (grant_q) rdata1_d = '0;
                    else         rdata0_d = '0;
                end
            end
            ST_DONE: begin
                prio_d  = ~grant_q;
                tmo_d   = 8'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign io_slv_valid   = (state_q == ST_ISSUE);
    assign io_slv_wr      = io_slv_valid & wr_q;
    assign io_slv_rd      = io_slv_valid & rd_q;
    assign io_slv_address = io_slv_valid ? addr_q  : '0;
    assign io_slv_wdata   = io_slv_valid ? wdata_q : '0;
    assign io_busy        = (state_q != ST_IDLE);

    assign io_m0_done  = (state_q == ST_DONE) & ~grant_q;
    assign io_m1_done  = (state_q == ST_DONE) &  grant_q;
    assign io_m0_err   = io_m0_done & err_q;
    assign io_m1_err   = io_m1_done & err_q;
    assign io_m0_rdata = rdata0_q;
    assign io_m1_rdata = rdata1_q;

endmodule

`default_nettype wire
